// File: rtl/game_tick_sched_if.sv
// Control and strobe bundle between the game tick scheduler and the game logic.
// The slave modport is the scheduler side; the master modport drives the pulses.
interface game_tick_sched_if #(
  parameter int unsigned W = 10
) ();
  logic         ms_tick;
  logic         start;
  logic         pause;
  logic         crash;
  logic         speed_up;
  logic [1:0]   state;
  logic         grav_stb;
  logic         scroll_stb;
  logic         anim_stb;
  logic [W-1:0] scroll_period;
  logic         overrun;

  modport master (
    output ms_tick, start, pause, crash, speed_up,
    input  state, grav_stb, scroll_stb, anim_stb, scroll_period, overrun
  );

  modport slave (
    input  ms_tick, start, pause, crash, speed_up,
    output state, grav_stb, scroll_stb, anim_stb, scroll_period, overrun
  );
endinterface

// File: rtl/game_tick_sched.sv
// Game state machine plus millisecond-driven gravity/scroll/animation strobes,
// serialised through one fixed-priority update slot (gravity > scroll > anim).
module game_tick_sched #(
  parameter int unsigned GRAV_PERIOD   = 20,
  parameter int unsigned SCROLL_PERIOD = 10,
  parameter int unsigned MIN_SCROLL    = 4,
  parameter int unsigned ANIM_PERIOD   = 250,
  parameter int unsigned W             = 10
) (
  input logic               clk,
  input logic               rst,
  game_tick_sched_if.slave  bus
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StPause = 2'd2,
    StOver  = 2'd3
  } state_e;

  // Channel index: 0 = gravity, 1 = scroll, 2 = animation.
  state_e       state_q, state_d;
  logic [W-1:0] cnt_q [3];
  logic [W-1:0] cnt_d [3];
  logic [2:0]   pend_q, pend_d;
  logic [2:0]   stb_q, stb_d;
  logic [W-1:0] period_q, period_d;
  logic         ovr_q, ovr_d;

  logic [W-1:0] per_m1 [3];
  logic [2:0]   cnt_en;
  logic [2:0]   expire;
  logic [2:0]   eligible;
  logic [2:0]   req;
  logic [2:0]   grant;
  logic         entering_run;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StIdle;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
      pend_q   <= '0;
      stb_q    <= '0;
      period_q <= W'(SCROLL_PERIOD);
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
      pend_q   <= pend_d;
      stb_q    <= stb_d;
      period_q <= period_d;
      ovr_q    <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (bus.start) state_d = StRun;
      StRun: begin
        if (bus.crash)      state_d = StOver;
        else if (bus.pause) state_d = StPause;
      end
      StPause: if (bus.pause) state_d = StRun;
      StOver:  if (bus.start) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    per_m1[0] = W'(GRAV_PERIOD - 1);
    per_m1[1] = period_q - W'(1);
    per_m1[2] = W'(ANIM_PERIOD - 1);
    cnt_en    = {state_q != StPause, state_q == StRun, state_q == StRun};
    entering_run = (state_q == StIdle) && (state_d == StRun);

    // Counters see the tick in the pre-transition state.
    expire = '0;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = cnt_q[i];
      if (bus.ms_tick && cnt_en[i]) begin
        if (cnt_q[i] >= per_m1[i]) begin
          cnt_d[i]  = '0;
          expire[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + W'(1);
        end
      end
    end
    if (entering_run) begin
      cnt_d[0] = '0;
      cnt_d[1] = '0;
    end

    // Only grant channels whose strobe is legal in the state the strobe lands in.
    eligible = {state_d != StPause, state_d == StRun, state_d == StRun};
    req      = pend_q & eligible;
    if (req[0])      grant = 3'b001;
    else if (req[1]) grant = 3'b010;
    else if (req[2]) grant = 3'b100;
    else             grant = 3'b000;
    stb_d = grant;

    pend_d = (pend_q & ~grant) | expire;
    ovr_d  = ovr_q | (|(expire & pend_q));
    if (state_q == StRun && state_d != StRun)     pend_d[1:0] = 2'b00;
    if (state_q != StPause && state_d == StPause) pend_d[2]   = 1'b0;

    period_d = period_q;
    if (entering_run) begin
      period_d = W'(SCROLL_PERIOD);
      ovr_d    = 1'b0;
    end else if (state_q == StRun && bus.speed_up && !bus.crash &&
                 period_q > W'(MIN_SCROLL)) begin
      period_d = period_q - W'(1);
    end
  end

  assign bus.state         = state_q;
  assign bus.grav_stb      = stb_q[0];
  assign bus.scroll_stb    = stb_q[1];
  assign bus.anim_stb      = stb_q[2];
  assign bus.scroll_period = period_q;
  assign bus.overrun       = ovr_q;

endmodule

// File: tb/tb_game_tick_sched.sv
// Scoreboard bench: a default-parameter scheduler and a fast one (all periods tiny)
// share the same stimulus; a behavioural model predicts every cycle's outputs.
module tb_game_tick_sched;

  logic clk;
  logic rst;

  game_tick_sched_if #(.W(10)) bus0 ();
  game_tick_sched_if #(.W(10)) bus1 ();

  game_tick_sched #(
    .GRAV_PERIOD(20), .SCROLL_PERIOD(10), .MIN_SCROLL(4), .ANIM_PERIOD(250), .W(10)
  ) u_dut0 (
    .clk(clk),
    .rst(rst),
    .bus(bus0)
  );

  game_tick_sched #(
    .GRAV_PERIOD(1), .SCROLL_PERIOD(1), .MIN_SCROLL(1), .ANIM_PERIOD(3), .W(10)
  ) u_dut1 (
    .clk(clk),
    .rst(rst),
    .bus(bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state, one slot per DUT instance.
  int p_grav [2]  = '{20, 1};
  int p_scr0 [2]  = '{10, 1};
  int p_min  [2]  = '{4, 1};
  int p_anim [2]  = '{250, 3};
  int m_st   [2];
  int m_cnt  [2][3];
  bit m_pend [2][3];
  bit m_stb  [2][3];
  int m_per  [2];
  bit m_ovr  [2];

  logic [15:0] q0 [$];
  logic [15:0] q1 [$];

  // States: 0 idle, 1 run, 2 pause, 3 over.
  function automatic bit strobe_allowed(input int ch, input int st);
    if (ch < 2) return st == 1;
    return st != 2;
  endfunction

  task automatic model_step(input int k, input bit tk, input bit go, input bit pa,
                            input bit cr, input bit sp, input bit rv);
    int nst;
    int prd [3];
    bit exp_ch [3];
    int gr;
    if (!rv) begin
      m_st[k] = 0;
      for (int c = 0; c < 3; c++) begin
        m_cnt[k][c] = 0; m_pend[k][c] = 0; m_stb[k][c] = 0;
      end
      m_per[k] = p_scr0[k];
      m_ovr[k] = 0;
      return;
    end
    case (m_st[k])
      0:       nst = go ? 1 : 0;
      1:       nst = cr ? 3 : (pa ? 2 : 1);
      2:       nst = pa ? 1 : 2;
      default: nst = go ? 0 : 3;
    endcase
    prd[0] = p_grav[k]; prd[1] = m_per[k]; prd[2] = p_anim[k];
    for (int c = 0; c < 3; c++) begin
      exp_ch[c] = 0;
      if (tk && ((c < 2) ? (m_st[k] == 1) : (m_st[k] != 2))) begin
        // One more elapsed millisecond; fire once the period is reached.
        if (m_cnt[k][c] + 1 >= prd[c]) begin
          m_cnt[k][c] = 0;
          exp_ch[c] = 1;
        end else begin
          m_cnt[k][c]++;
        end
      end
    end
    gr = -1;
    for (int c = 0; c < 3; c++)
      if (gr < 0 && m_pend[k][c] && strobe_allowed(c, nst)) gr = c;
    for (int c = 0; c < 3; c++) begin
      m_stb[k][c] = (c == gr);
      if (exp_ch[c] && m_pend[k][c]) m_ovr[k] = 1;
    end
    if (gr >= 0) m_pend[k][gr] = 0;
    for (int c = 0; c < 3; c++) if (exp_ch[c]) m_pend[k][c] = 1;
    if (m_st[k] == 1 && nst != 1) begin
      m_pend[k][0] = 0; m_pend[k][1] = 0;
    end
    if (m_st[k] != 2 && nst == 2) m_pend[k][2] = 0;
    if (m_st[k] == 0 && nst == 1) begin
      m_per[k] = p_scr0[k];
      m_cnt[k][0] = 0; m_cnt[k][1] = 0;
      m_ovr[k] = 0;
    end else if (m_st[k] == 1 && sp && !cr && m_per[k] > p_min[k]) begin
      m_per[k]--;
    end
    m_st[k] = nst;
  endtask

  function automatic logic [15:0] exp_vec(input int k);
    logic [31:0] st;
    logic [31:0] per;
    st  = m_st[k];
    per = m_per[k];
    return {st[1:0], m_stb[k][0], m_stb[k][1], m_stb[k][2], per[9:0], m_ovr[k]};
  endfunction

  task automatic drive(input bit tk, input bit go, input bit pa, input bit cr,
                       input bit sp, input bit rv);
    @(negedge clk);
    rst = rv;
    bus0.ms_tick = tk; bus0.start = go; bus0.pause = pa; bus0.crash = cr; bus0.speed_up = sp;
    bus1.ms_tick = tk; bus1.start = go; bus1.pause = pa; bus1.crash = cr; bus1.speed_up = sp;
    model_step(0, tk, go, pa, cr, sp, rv);
    model_step(1, tk, go, pa, cr, sp, rv);
    q0.push_back(exp_vec(0));
    q1.push_back(exp_vec(1));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 1);
  endtask

  task automatic ticks(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      drive(1, 0, 0, 0, 0, 1);
      idle(gap);
    end
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
  endtask

  logic [15:0] got0, got1, want0, want1;

  always @(posedge clk) begin
    #1;
    if (q0.size() > 0) begin
      want0 = q0.pop_front();
      got0  = {bus0.state, bus0.grav_stb, bus0.scroll_stb, bus0.anim_stb,
               bus0.scroll_period, bus0.overrun};
      checks++;
      if (got0 !== want0) begin
        errors++;
        $display("FAIL dut0_outputs t=%0t got %h want %h", $time, got0, want0);
      end
      checks++;
      if ($countones({bus0.grav_stb, bus0.scroll_stb, bus0.anim_stb}) > 1) begin
        errors++;
        $display("FAIL dut0_onehot t=%0t got %b want at most one strobe", $time,
                 {bus0.grav_stb, bus0.scroll_stb, bus0.anim_stb});
      end
    end
    if (q1.size() > 0) begin
      want1 = q1.pop_front();
      got1  = {bus1.state, bus1.grav_stb, bus1.scroll_stb, bus1.anim_stb,
               bus1.scroll_period, bus1.overrun};
      checks++;
      if (got1 !== want1) begin
        errors++;
        $display("FAIL dut1_outputs t=%0t got %h want %h", $time, got1, want1);
      end
      checks++;
      if ($countones({bus1.grav_stb, bus1.scroll_stb, bus1.anim_stb}) > 1) begin
        errors++;
        $display("FAIL dut1_onehot t=%0t got %b want at most one strobe", $time,
                 {bus1.grav_stb, bus1.scroll_stb, bus1.anim_stb});
      end
    end
  end

  initial begin
    rst = 1'b0;
    bus0.ms_tick = 0; bus0.start = 0; bus0.pause = 0; bus0.crash = 0; bus0.speed_up = 0;
    bus1.ms_tick = 0; bus1.start = 0; bus1.pause = 0; bus1.crash = 0; bus1.speed_up = 0;

    // Reset then idle: only the animation channel runs.
    do_reset();
    ticks(250, 1);
    idle(4);

    // Normal run.
    drive(0, 1, 0, 0, 0, 1);
    ticks(20, 3);

    // Pause / resume.
    do_reset();
    drive(0, 1, 0, 0, 0, 1);
    ticks(5, 2);
    drive(0, 0, 1, 0, 0, 1);
    ticks(100, 1);
    drive(0, 0, 1, 0, 0, 1);
    ticks(5, 3);

    // Speed-up floor, and a shortened period below the current count.
    do_reset();
    drive(0, 1, 0, 0, 0, 1);
    ticks(7, 2);
    for (int i = 0; i < 8; i++) drive(0, 0, 0, 0, 1, 1);
    ticks(12, 3);

    // Crash with pause in the same cycle, speed_up ignored alongside crash, restart.
    drive(0, 0, 1, 1, 1, 1);
    ticks(30, 1);
    drive(0, 1, 0, 0, 0, 1);
    idle(2);
    drive(0, 1, 0, 0, 0, 1);
    ticks(15, 3);

    // Tick on the same cycle as pause still counts in RUN.
    drive(1, 0, 1, 0, 0, 1);
    idle(3);
    drive(1, 0, 1, 0, 0, 1);
    idle(3);

    // Overrun: back-to-back ticks saturate the fast instance.
    drive(0, 0, 0, 1, 0, 1);
    drive(0, 1, 0, 0, 0, 1);
    drive(0, 1, 0, 0, 0, 1);
    ticks(20, 0);
    ticks(5, 2);
    do_reset();
    idle(3);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 5,
            $urandom_range(0, 99) < 3,  $urandom_range(0, 99) < 2,
            $urandom_range(0, 99) < 5,  $urandom_range(0, 499) != 0);
    end

    idle(3);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d/%0d entries want 0/0", q0.size(), q1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_tick_sched.md
# game_tick_sched

Game-time scheduler that sits between the 1 kHz millisecond tick generator and the game logic. It owns the top-level game state machine (IDLE/RUN/PAUSE/OVER) and turns the shared `ms_tick` pulse into three periodic update strobes: bird gravity, pipe scroll and sprite animation. The strobes share a single game-logic update slot, so at most one strobe is asserted per clock and coincident requests are serialised by fixed priority. The block also holds the current scroll period, which speeds up under game control.

## Interface
- `GRAV_PERIOD`, 20: gravity strobe period, in ms.
- `SCROLL_PERIOD`, 10: initial pipe-scroll period, in ms.
- `MIN_SCROLL`, 4: lower bound of the scroll period after speed-ups.
- `ANIM_PERIOD`, 250: animation strobe period, in ms.
- `W`, 10: width of the period counters.
- `clk`  in  1  system clock.
- `rst`  in  1  reset; synchronous, active-low.
- `ms_tick`  in  1  one-cycle pulse, once per millisecond.
- `start`  in  1  one-cycle pulse; in IDLE, starts a game; in OVER, returns to IDLE.
- `pause`  in  1  one-cycle pulse; toggles between RUN and PAUSE.
- `crash`  in  1  one-cycle pulse; in RUN, ends the game.
- `speed_up`  in  1  one-cycle pulse; in RUN, shortens the scroll period by 1.
- `state`  out  2  0=IDLE, 1=RUN, 2=PAUSE, 3=OVER.
- `grav_stb`  out  1  one-cycle gravity update strobe.
- `scroll_stb`  out  1  one-cycle pipe-scroll strobe.
- `anim_stb`  out  1  one-cycle animation strobe.
- `scroll_period`  out  W  scroll period currently in effect.
- `overrun`  out  1  sticky flag; a channel expired again while its previous request was still pending.

## Operation
- **Reset (rst=0 at a clk edge):**
  - state=IDLE; all strobes 0; all counters 0; all pending bits 0.
  - scroll_period=SCROLL_PERIOD; overrun=0.
  - Reset mid-game aborts immediately. No strobe is asserted in the cycle after reset.
- **FSM transitions**, evaluated in priority order crash > pause > start:
  - IDLE → RUN on start.
  - RUN → OVER on crash.
  - RUN → PAUSE on pause.
  - PAUSE → RUN on pause.
  - OVER → IDLE on start.
  - All other inputs are ignored in the current state (e.g. crash in PAUSE, speed_up outside RUN).
- **IDLE → RUN entry:** gravity and scroll counters are cleared, scroll_period is reloaded to SCROLL_PERIOD, and overrun is cleared.
- **Channel counters:** each counter advances only on `ms_tick`.
  - Gravity and scroll counters count only in RUN and hold in PAUSE.
  - The animation counter counts in IDLE, RUN and OVER, and holds in PAUSE.
  - On a tick where counter ≥ period−1, the counter wraps to 0 and sets that channel's pending bit. Otherwise it increments.
  - The ≥ compare guarantees that a period shortened below the current count still fires on the next tick.
- **Arbitration:** each cycle, the highest-priority pending bit is granted, in order gravity > scroll > anim.
  - The granted strobe is asserted on the next cycle and its pending bit is cleared.
  - Strobes are mutually exclusive (one-hot or zero).
- **Overrun:** if a channel expires while its pending bit is already set, the bit stays set (no double request) and overrun is set to 1 until reset or the next game start.
- **Leaving RUN:** gravity and scroll pending bits are cleared whenever state leaves RUN. The anim pending bit is cleared on entry to PAUSE.
- **speed_up in RUN:** scroll_period decrements by 1 if it is greater than MIN_SCROLL; otherwise it is unchanged. A speed_up coincident with a scroll expiry affects the following period.

## Timing
- state updates one clock after the qualifying input pulse.
- Strobe latency: a counter expiry registered at edge N produces the strobe during cycle N+1 when uncontested. Each lower priority level adds 1 cycle, so worst case is N+3.
- ms_tick and pause on the same cycle: the tick is applied using the pre-transition state, so RUN still counts that tick.
- crash and speed_up on the same cycle: crash wins and scroll_period is unchanged.
- Strobes are never asserted in PAUSE, IDLE or OVER except anim_stb, which is also allowed in IDLE and OVER.
- Outputs are registered; there is no combinational path from input to output.

## Test plan
- **Reset then idle:** hold rst=0 for 2 cycles, release, issue 250 ms_ticks → state=0, grav_stb and scroll_stb never asserted, exactly one anim_stb, scroll_period=10.
- **Normal run:** start, then 20 ms_ticks → exactly 2 scroll_stb (at ticks 10 and 20) and 1 grav_stb (tick 20). At tick 20, grav_stb is asserted one cycle after the expiry and scroll_stb the cycle after that; never both in the same cycle.
- **Pause/resume:** start, 5 ticks, pause, 100 ticks, pause, 5 ticks → state 1→2→1, no strobes during PAUSE, first scroll_stb on the 5th tick after resume.
- **Speed-up floor:** in RUN, issue 8 speed_up pulses → scroll_period steps 9, 8, …, 4 and stays at 4. With the counter at 7 and the period dropped to 4, the next tick fires scroll_stb and the counter wraps to 0.
- **Crash and restart:** crash and pause on the same cycle in RUN → state=3, pending cleared, no further grav/scroll strobes. Then start → state=0; start again → state=1 with counters at 0 and overrun=0.
- **Overrun:** drive ms_tick on consecutive cycles with GRAV_PERIOD=1 and SCROLL_PERIOD=1 → overrun=1, strobes stay one-hot, and overrun stays 1 until reset.
